// File: rtl/spiral_pack_if.sv
// Stream bus for spiral_pack: element input, frame dimensions and packed word output.
// SPIRAL_PACK_PARITY_EN adds the per-lane parity output out_par.
interface spiral_pack_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned R_WIDTH    = 3,
  parameter int unsigned C_WIDTH    = 3,
  parameter int unsigned LANES      = 4
);
  logic [R_WIDTH-1:0]          row;
  logic [C_WIDTH-1:0]          col;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_valid;
  logic                        in_rdy;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [LANES-1:0]            out_keep;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_rdy;
`ifdef SPIRAL_PACK_PARITY_EN
  logic [LANES-1:0]            out_par;

  modport master (
    output row, col, in_data, in_valid, out_rdy,
    input  in_rdy, out_data, out_keep, out_last, out_valid, out_par
  );
  modport slave (
    input  row, col, in_data, in_valid, out_rdy,
    output in_rdy, out_data, out_keep, out_last, out_valid, out_par
  );
`else
  modport master (
    output row, col, in_data, in_valid, out_rdy,
    input  in_rdy, out_data, out_keep, out_last, out_valid
  );
  modport slave (
    input  row, col, in_data, in_valid, out_rdy,
    output in_rdy, out_data, out_keep, out_last, out_valid
  );
`endif
endinterface

// File: rtl/spiral_pack.sv
// Packs the spiral element stream into LANES-wide words, flushing a partial word at frame end.
// SPIRAL_PACK_PARITY_EN adds registered per-lane even parity on out_par.
module spiral_pack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned R_WIDTH    = 3,
  parameter int unsigned C_WIDTH    = 3,
  parameter int unsigned LANES      = 4
) (
  input logic       clk,
  input logic       rstn,
  spiral_pack_if.slave bus
);

  localparam int unsigned TW = R_WIDTH + C_WIDTH;
  localparam int unsigned LW = $clog2(LANES);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                                state_q, state_d;
  logic                                  rdy_en_q;
  logic [LW-1:0]                         lane_q, lane_d;
  logic [TW-1:0]                         cnt_q, cnt_d;
  logic [TW-1:0]                         total_q, total_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]      acc_q, acc_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [LANES-1:0]                      out_keep_q, out_keep_d;
  logic                                  out_last_q, out_last_d;
  logic                                  out_valid_q, out_valid_d;
`ifdef SPIRAL_PACK_PARITY_EN
  logic [LANES-1:0]                      out_par_q, out_par_d;
`endif

  logic                                  in_idle;
  logic                                  accept;
  logic [R_WIDTH-1:0]                    row_eff;
  logic [C_WIDTH-1:0]                    col_eff;
  logic [TW-1:0]                         new_total;
  logic [TW-1:0]                         eff_total;
  logic [TW-1:0]                         elem_num;
  logic                                  is_end;
  logic                                  word_done;
  logic [LANES-1:0][DATA_WIDTH-1:0]      acc_word;
  logic [LANES-1:0]                      keep_mask;

  // in_rdy stays low through reset and for the first edge after release.
  assign bus.in_rdy = rdy_en_q && (!out_valid_q || bus.out_rdy);
  assign accept     = bus.in_valid && bus.in_rdy;

  // Zero dimensions are illegal upstream; treat them as 1 so a frame always terminates.
  assign row_eff   = (bus.row == '0) ? R_WIDTH'(1) : bus.row;
  assign col_eff   = (bus.col == '0) ? C_WIDTH'(1) : bus.col;
  assign new_total = TW'(row_eff) * TW'(col_eff);
  assign eff_total = in_idle ? new_total : total_q;
  assign elem_num  = cnt_q + TW'(1);
  assign is_end    = (elem_num == eff_total);
  assign word_done = (lane_q == LW'(LANES - 1)) || is_end;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && !is_end) state_d = StFill;
      StFill: if (accept && is_end)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_idle = (state_q == StIdle);
  end

  always_comb begin
    acc_word         = acc_q;
    acc_word[lane_q] = bus.in_data;
    for (int unsigned k = 0; k < LANES; k++) begin
      keep_mask[k] = (LW'(k) <= lane_q);
    end
  end

  always_comb begin
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
`ifdef SPIRAL_PACK_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (bus.out_rdy) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      total_d = eff_total;
      if (word_done) begin
        // Lanes beyond lane_q are already zero because the accumulator clears per word.
        out_data_d  = acc_word;
        out_keep_d  = keep_mask;
        out_last_d  = is_end;
        out_valid_d = 1'b1;
`ifdef SPIRAL_PACK_PARITY_EN
        for (int unsigned k = 0; k < LANES; k++) begin
          out_par_d[k] = (^acc_word[k]) & keep_mask[k];
        end
`endif
        acc_d  = '0;
        lane_d = '0;
        cnt_d  = is_end ? '0 : elem_num;
      end else begin
        acc_d  = acc_word;
        lane_d = lane_q + LW'(1);
        cnt_d  = elem_num;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q    <= 1'b0;
      lane_q      <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SPIRAL_PACK_PARITY_EN
      out_par_q   <= '0;
`endif
    end else begin
      rdy_en_q    <= 1'b1;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
`ifdef SPIRAL_PACK_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
`ifdef SPIRAL_PACK_PARITY_EN
  assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_spiral_pack.sv
// Directed bench for spiral_pack: packing, flush, backpressure, back-to-back frames, reset.
module tb_spiral_pack;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned LN = 4;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;

  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_last[$];
`ifdef SPIRAL_PACK_PARITY_EN
  logic [3:0]  got_par[$];
`endif

  spiral_pack_if #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW), .LANES(LN)) bus ();

  spiral_pack #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW), .LANES(LN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A word is consumed on the next rising edge when valid && rdy at the falling edge.
  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_rdy) begin
      got_data.push_back(bus.out_data);
      got_keep.push_back(bus.out_keep);
      got_last.push_back(bus.out_last);
`ifdef SPIRAL_PACK_PARITY_EN
      got_par.push_back(bus.out_par);
`endif
    end
  end

  task automatic clear_q();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
`ifdef SPIRAL_PACK_PARITY_EN
    got_par.delete();
`endif
  endtask

  task automatic push(input logic [7:0] d);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_rdy) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: in_rdy=%b required 1", bus.in_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.in_rdy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.out_keep !== 4'h0 || bus.out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b valid=%b last=%b keep=%h data=%h required 0 0 0 0 0",
               bus.in_rdy, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdy_before_first_clk: in_rdy=%b required 0", bus.in_rdy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.in_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rdy_after_release: in_rdy=%b required 1", bus.in_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_3x3();
    logic [31:0] ed[3] = '{32'h04030201, 32'h08070605, 32'h00000009};
    logic [3:0]  ek[3] = '{4'hF, 4'hF, 4'h1};
    logic        el[3] = '{1'b0, 1'b0, 1'b1};
    clear_q();
    bus.row = 3'd3;
    bus.col = 3'd3;
    push(8'd1);
    // Dimension changes mid-frame must be ignored.
    bus.row = 3'd1;
    bus.col = 3'd1;
    for (int i = 2; i <= 9; i++) push(8'(i));
    end_frame();
    tests_run++;
    if (got_data.size() != 3) begin
      tests_failed++;
      $display("FAIL 3x3_count: words=%0d required 3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_data[i] !== ed[i] || got_keep[i] !== ek[i] || got_last[i] !== el[i]) begin
          tests_failed++;
          $display("FAIL 3x3_word%0d: data=%h keep=%h last=%b required %h %h %b",
                   i, got_data[i], got_keep[i], got_last[i], ed[i], ek[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_2x2();
    clear_q();
    bus.row = 3'd2;
    bus.col = 3'd2;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    end_frame();
    tests_run++;
    if (got_data.size() != 1 || got_data[0] !== 32'hA3A2A1A0 || got_keep[0] !== 4'hF ||
        got_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL 2x2_word: words=%0d data=%h keep=%h last=%b required 1 a3a2a1a0 f 1",
               got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx,
               got_keep.size() > 0 ? got_keep[0] : 4'hx,
               got_last.size() > 0 ? got_last[0] : 1'bx);
    end
    tests_run++;
    if (dut.state_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL 2x2_idle: state=%b required 0", dut.state_q);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed[3] = '{32'h04030201, 32'h08070605, 32'h00000009};
    clear_q();
    bus.row     = 3'd3;
    bus.col     = 3'd3;
    bus.out_rdy = 1'b0;
    fork
      begin
        for (int i = 1; i <= 9; i++) push(8'(i));
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        for (int c = 0; c < 5; c++) begin
          tests_run++;
          if (bus.in_rdy !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 ||
              bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_cycle%0d: rdy=%b valid=%b data=%h keep=%h last=%b required 0 1 04030201 f 0",
                     c, bus.in_rdy, bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_rdy = 1'b1;
      end
    join
    end_frame();
    tests_run++;
    if (got_data.size() != 3) begin
      tests_failed++;
      $display("FAIL bp_count: words=%0d required 3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_data[i] !== ed[i]) begin
          tests_failed++;
          $display("FAIL bp_word%0d: data=%h required %h", i, got_data[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    bus.row = 3'd1;
    bus.col = 3'd3;
    push(8'd11); push(8'd12); push(8'd13);
    bus.row = 3'd1;
    bus.col = 3'd2;
    push(8'd21); push(8'd22);
    end_frame();
    tests_run++;
    if (got_data.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: words=%0d required 2", got_data.size());
    end else begin
      tests_run++;
      if (got_data[0] !== 32'h000D0C0B || got_keep[0] !== 4'h7 || got_last[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_word0: data=%h keep=%h last=%b required 000d0c0b 7 1",
                 got_data[0], got_keep[0], got_last[0]);
      end
      tests_run++;
      if (got_data[1] !== 32'h00001615 || got_keep[1] !== 4'h3 || got_last[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_word1: data=%h keep=%h last=%b required 00001615 3 1",
                 got_data[1], got_keep[1], got_last[1]);
      end
    end
  endtask

  task automatic test_zero_dim();
    clear_q();
    bus.row = 3'd0;
    bus.col = 3'd2;
    push(8'h31); push(8'h32);
    bus.row = 3'd0;
    bus.col = 3'd0;
    push(8'h41);
    end_frame();
    tests_run++;
    if (got_data.size() != 2) begin
      tests_failed++;
      $display("FAIL zero_count: words=%0d required 2", got_data.size());
    end else begin
      tests_run++;
      if (got_data[0] !== 32'h00003231 || got_keep[0] !== 4'h3 || got_last[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL zero_row: data=%h keep=%h last=%b required 00003231 3 1",
                 got_data[0], got_keep[0], got_last[0]);
      end
      tests_run++;
      if (got_data[1] !== 32'h00000041 || got_keep[1] !== 4'h1 || got_last[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL zero_both: data=%h keep=%h last=%b required 00000041 1 1",
                 got_data[1], got_keep[1], got_last[1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bus.row = 3'd3;
    bus.col = 3'd3;
    for (int i = 1; i <= 6; i++) push(8'(i));
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_rdy !== 1'b0 || bus.out_keep !== 4'h0) begin
      tests_failed++;
      $display("FAIL midreset_state: valid=%b rdy=%b keep=%h required 0 0 0",
               bus.out_valid, bus.in_rdy, bus.out_keep);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    bus.row = 3'd2;
    bus.col = 3'd2;
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    end_frame();
    tests_run++;
    if (got_data.size() != 1 || got_data[0] !== 32'hB3B2B1B0 || got_keep[0] !== 4'hF ||
        got_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_fresh: words=%0d data=%h required 1 b3b2b1b0 keep f last",
               got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx);
    end
  endtask

`ifdef SPIRAL_PACK_PARITY_EN
  task automatic test_parity();
    clear_q();
    bus.row = 3'd2;
    bus.col = 3'd2;
    push(8'h00); push(8'h01); push(8'h03); push(8'h07);
    end_frame();
    tests_run++;
    if (got_data.size() != 1 || got_data[0] !== 32'h07030100 || got_par[0] !== 4'b1010) begin
      tests_failed++;
      $display("FAIL parity: words=%0d data=%h par=%b required 1 07030100 1010",
               got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx,
               got_par.size() > 0 ? got_par[0] : 4'hx);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.row      = '0;
    bus.col      = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_rdy  = 1'b1;
    test_reset();
    test_3x3();
    test_2x2();
    test_backpressure();
    test_back_to_back();
    test_zero_dim();
    test_reset_midframe();
`ifdef SPIRAL_PACK_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
